prio_encoder_rr: RTL and testbench

- Parametrised, registered priority encoder that turns an IN_SIZE-bit request vector into the OUT_SIZE-bit index of one set bit.
- Two modes:
  - Fixed: the lowest set bit wins.
  - Round-robin: search starts at a rotating pointer and wraps.
- Valid/ready handshakes on input and output, plus a one-cycle result register.
- Sits between request sources and arbitration/steering logic; extends the combinational encoder with fairness, back-pressure, a "none" indication and a one-hot grant.

---
 rtl/prio_enc_pkg.sv | 13 +
 rtl/prio_enc_core.sv | 60 ++++++
 rtl/prio_encoder_rr.sv | 74 +++++++
 tb/tb_prio_encoder_rr.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared mode encoding and round-robin pointer wrap for prio_encoder_rr
package prio_enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int next_ptr(input int w, input int in_size);
    return (w == in_size - 1) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// rtl/prio_enc_core.sv - combinational masked two-pass lowest-set-bit search
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic [IN_SIZE-1:0]  i_req,
  input  logic [OUT_SIZE-1:0] i_start,
  input  logic                i_mode,
  output logic [OUT_SIZE-1:0] o_index,
  output logic [IN_SIZE-1:0]  o_onehot,
  output logic                o_none
);

  logic [IN_SIZE-1:0]  w_masked;
  logic [OUT_SIZE-1:0] w_idx_masked;
  logic [OUT_SIZE-1:0] w_idx_full;
  logic                w_found_masked;
  logic                w_found_full;

  // First pass only sees bits at or above the start pointer; second pass is the wrap.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      if (mode_e'(i_mode) == MODE_RR) begin
        w_masked[i] = i_req[i] && (i >= int'(i_start));
      end else begin
        w_masked[i] = i_req[i];
      end
    end
  end

  always_comb begin
    w_idx_masked   = '0;
    w_found_masked = 1'b0;
    w_idx_full     = '0;
    w_found_full   = 1'b0;
    for (int i = IN_SIZE - 1; i >= 0; i--) begin
      if (w_masked[i]) begin
        w_idx_masked   = OUT_SIZE'(i);
        w_found_masked = 1'b1;
      end
      if (i_req[i]) begin
        w_idx_full   = OUT_SIZE'(i);
        w_found_full = 1'b1;
      end
    end
  end

  always_comb begin
    o_none   = !w_found_full;
    o_index  = w_found_masked ? w_idx_masked : w_idx_full;
    o_onehot = '0;
    if (w_found_full) begin
      o_onehot = {{(IN_SIZE-1){1'b0}}, 1'b1} << o_index;
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered fixed/round-robin priority encoder with valid/ready handshakes
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int OUT_SIZE = 4,
  parameter int IN_SIZE  = 1 << OUT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_SIZE-1:0] enc_out,
  output logic [IN_SIZE-1:0]  out_onehot,
  output logic                out_none
);

  logic                r_valid;
  logic [OUT_SIZE-1:0] r_enc;
  logic [IN_SIZE-1:0]  r_onehot;
  logic                r_none;
  logic [OUT_SIZE-1:0] r_ptr;

  logic                w_accept;
  logic [OUT_SIZE-1:0] w_idx;
  logic [IN_SIZE-1:0]  w_onehot;
  logic                w_none;

  prio_enc_core #(
    .OUT_SIZE (OUT_SIZE),
    .IN_SIZE  (IN_SIZE)
  ) u_core (
    .i_req    (in),
    .i_start  (r_ptr),
    .i_mode   (mode),
    .o_index  (w_idx),
    .o_onehot (w_onehot),
    .o_none   (w_none)
  );

  assign in_ready = enable && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // A capture always wins over a drain, so drain+accept on one edge keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_enc    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_enc    <= w_idx;
      r_onehot <= w_onehot;
      r_none   <= w_none;
      if (mode_e'(mode) == MODE_RR && !w_none) begin
        r_ptr <= OUT_SIZE'(next_ptr(int'(w_idx), IN_SIZE));
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign enc_out    = r_enc;
  assign out_onehot = r_onehot;
  assign out_none   = r_none;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - self-checking bench for prio_encoder_rr against a rotating-search model
module tb_prio_encoder_rr;

  localparam int OS = 4;
  localparam int N  = 16;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in;
  logic          out_valid;
  logic          out_ready;
  logic [OS-1:0] enc_out;
  logic [N-1:0]  out_onehot;
  logic          out_none;

  int n_pass;
  int n_total;

  int           m_ptr;
  int           exp_idx;
  logic         exp_none;
  logic [N-1:0] exp_onehot;

  prio_encoder_rr #(.OUT_SIZE(OS), .IN_SIZE(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .enc_out    (enc_out),
    .out_onehot (out_onehot),
    .out_none   (out_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rotate from the pointer and take the first set bit encountered.
  task automatic model_step(input logic [N-1:0] v, input logic md);
    exp_none = (v == '0);
    exp_idx  = 0;
    if (v != '0) begin
      if (md == 1'b0) begin
        for (int i = N - 1; i >= 0; i--) if (v[i]) exp_idx = i;
      end else begin
        for (int k = N - 1; k >= 0; k--) if (v[(m_ptr + k) % N]) exp_idx = (m_ptr + k) % N;
        m_ptr = (exp_idx == N - 1) ? 0 : exp_idx + 1;
      end
    end
    exp_onehot = exp_none ? '0 : (N'(1) << exp_idx);
  endtask

  task automatic push(input logic [N-1:0] v, input logic md);
    in       = v;
    mode     = md;
    in_valid = 1'b1;
    model_step(v, md);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; mode = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b1;
    m_ptr = 0;
    #2;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (enc_out !== '0) $display("FAIL reset_enc_out got %0d want 0", enc_out); else n_pass++;
    n_total++; if (out_onehot !== '0) $display("FAIL reset_onehot got %h want 0", out_onehot); else n_pass++;
    n_total++; if (out_none !== 1'b0) $display("FAIL reset_none got %b want 0", out_none); else n_pass++;
    n_total++; if (dut.r_ptr !== '0) $display("FAIL reset_ptr got %0d want 0", dut.r_ptr); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed();
    push(16'h0028, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL fixed_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (enc_out !== 4'd3) $display("FAIL fixed_enc got %0d want 3", enc_out); else n_pass++;
    n_total++; if (out_onehot !== 16'h0008) $display("FAIL fixed_onehot got %h want 0008", out_onehot); else n_pass++;
    n_total++; if (out_none !== 1'b0) $display("FAIL fixed_none got %b want 0", out_none); else n_pass++;
    push(16'h8000, 1'b0);
    n_total++; if (enc_out !== 4'd15) $display("FAIL fixed_msb got %0d want 15", enc_out); else n_pass++;
    n_total++; if (dut.r_ptr !== 4'd0) $display("FAIL fixed_ptr got %0d want 0", dut.r_ptr); else n_pass++;
  endtask

  task automatic test_rr_seq();
    int exp_e[4] = '{0, 4, 8, 0};
    int exp_p[4] = '{1, 5, 9, 1};
    for (int t = 0; t < 4; t++) begin
      push(16'h0111, 1'b1);
      n_total++; if (int'(enc_out) !== exp_e[t]) $display("FAIL rr_seq_enc[%0d] got %0d want %0d", t, enc_out, exp_e[t]); else n_pass++;
      n_total++; if (int'(dut.r_ptr) !== exp_p[t]) $display("FAIL rr_seq_ptr[%0d] got %0d want %0d", t, dut.r_ptr, exp_p[t]); else n_pass++;
    end
  endtask

  task automatic test_rr_wrap();
    push(16'h4000, 1'b1);
    n_total++; if (dut.r_ptr !== 4'd15) $display("FAIL wrap_setup_ptr got %0d want 15", dut.r_ptr); else n_pass++;
    push(16'h8001, 1'b1);
    n_total++; if (enc_out !== 4'd15) $display("FAIL wrap_enc got %0d want 15", enc_out); else n_pass++;
    n_total++; if (dut.r_ptr !== 4'd0) $display("FAIL wrap_ptr got %0d want 0", dut.r_ptr); else n_pass++;
    push(16'h8001, 1'b1);
    n_total++; if (enc_out !== 4'd0) $display("FAIL wrap_next_enc got %0d want 0", enc_out); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [OS-1:0] held;
    out_ready = 1'b1;
    push(16'h0010, 1'b1);
    held = enc_out;
    n_total++; if (int'(enc_out) !== exp_idx) $display("FAIL bp_first_enc got %0d want %0d", enc_out, exp_idx); else n_pass++;
    out_ready = 1'b0;
    in        = 16'h0100;
    in_valid  = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== 1'b1 || enc_out !== held || in_ready !== 1'b0)
        $display("FAIL bp_hold[%0d] got v=%b enc=%0d rdy=%b want v=1 enc=%0d rdy=0", c, out_valid, enc_out, in_ready, held);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready); else n_pass++;
    model_step(16'h0100, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_drain_accept_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (enc_out !== 4'd8) $display("FAIL bp_drain_accept_enc got %0d want 8", enc_out); else n_pass++;
  endtask

  task automatic test_none();
    logic [OS-1:0] p0;
    for (int md = 0; md < 2; md++) begin
      p0 = dut.r_ptr;
      push(16'h0000, md[0]);
      n_total++;
      if (out_valid !== 1'b1 || out_none !== 1'b1 || enc_out !== '0 || out_onehot !== '0)
        $display("FAIL none_mode%0d got v=%b none=%b enc=%0d oh=%h want 1 1 0 0000", md, out_valid, out_none, enc_out, out_onehot);
      else n_pass++;
      n_total++; if (dut.r_ptr !== p0) $display("FAIL none_ptr_mode%0d got %0d want %0d", md, dut.r_ptr, p0); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL none_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_enable_reset();
    logic [OS-1:0] held;
    logic [OS-1:0] p0;
    push(16'h0002, 1'b1);
    held = enc_out;
    p0   = dut.r_ptr;
    enable = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in = 16'hFFFF;
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL en_in_ready got %b want 0", in_ready); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (out_valid !== 1'b1 || enc_out !== held || dut.r_ptr !== p0)
      $display("FAIL en_no_capture got v=%b enc=%0d ptr=%0d want 1 %0d %0d", out_valid, enc_out, dut.r_ptr, held, p0);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || enc_out !== '0 || dut.r_ptr !== '0)
      $display("FAIL async_reset got v=%b enc=%0d ptr=%0d want 0 0 0", out_valid, enc_out, dut.r_ptr);
    else n_pass++;
    m_ptr = 0;
    in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    push(16'h0006, 1'b1);
    n_total++; if (enc_out !== 4'd1) $display("FAIL post_reset_enc got %0d want 1", enc_out); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic         e_valid;
    int           e_idx;
    logic         e_none;
    logic [N-1:0] e_oh;
    logic         e_rdy;
    logic         acc;
    e_valid = out_valid; e_idx = int'(enc_out); e_none = out_none; e_oh = out_onehot;
    for (int it = 0; it < 300; it++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      enable    = ($urandom_range(7) != 0);
      mode      = $urandom_range(1);
      case ($urandom_range(3))
        0:       in = '0;
        1:       in = N'(1) << $urandom_range(N - 1);
        default: in = N'($urandom);
      endcase
      #1;
      e_rdy = enable && (!e_valid || out_ready);
      n_total++; if (in_ready !== e_rdy) $display("FAIL rand_in_ready[%0d] got %b want %b", it, in_ready, e_rdy); else n_pass++;
      acc = in_valid && e_rdy;
      if (acc) begin
        model_step(in, mode);
        e_valid = 1'b1; e_idx = exp_idx; e_none = exp_none; e_oh = exp_onehot;
      end else if (e_valid && out_ready) begin
        e_valid = 1'b0;
      end
      @(posedge clk); #1;
      n_total++;
      if (out_valid !== e_valid || (e_valid && (int'(enc_out) !== e_idx || out_none !== e_none || out_onehot !== e_oh)))
        $display("FAIL rand_out[%0d] got v=%b enc=%0d none=%b oh=%h want v=%b enc=%0d none=%b oh=%h",
                 it, out_valid, enc_out, out_none, out_onehot, e_valid, e_idx, e_none, e_oh);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fixed();
    test_rr_seq();
    test_rr_wrap();
    test_back_to_back();
    test_none();
    test_enable_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
